s2mm_burst_scheduler: RTL and testbench

Moves a continuous AXI-Stream sample flow into the DDR ring buffers owned by the sync manager. Incoming samples are held in an internal FIFO, and the block issues fixed-length AXI4 write bursts at the manager's current write address. It pulses the manager's write-advance strobe once per accepted data beat. One burst is in flight at a time; an overflow counter tracks samples dropped when memory cannot keep up.

---
 rtl/s2mm_burst_scheduler_if.sv | 36 +++
 rtl/s2mm_burst_scheduler.sv | 168 ++++++++++++++++
 tb/tb_s2mm_burst_scheduler.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/s2mm_burst_scheduler_if.sv
// AXI4 write-channel bundle between the S2MM burst scheduler and memory.
//   master : the scheduler (drives AW/W, receives B)
//   slave  : the memory / interconnect side
interface s2mm_burst_scheduler_if #(
  parameter int MM_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic [MM_ADDR_WIDTH-1:0] M_AXI_awaddr;
  logic [7:0]               M_AXI_awlen;
  logic [2:0]               M_AXI_awsize;
  logic [1:0]               M_AXI_awburst;
  logic                     M_AXI_awvalid;
  logic                     M_AXI_awready;
  logic [DATA_WIDTH-1:0]    M_AXI_wdata;
  logic [DATA_WIDTH/8-1:0]  M_AXI_wstrb;
  logic                     M_AXI_wlast;
  logic                     M_AXI_wvalid;
  logic                     M_AXI_wready;
  logic [1:0]               M_AXI_bresp;
  logic                     M_AXI_bvalid;
  logic                     M_AXI_bready;

  modport master (
    output M_AXI_awaddr, M_AXI_awlen, M_AXI_awsize, M_AXI_awburst, M_AXI_awvalid,
    output M_AXI_wdata, M_AXI_wstrb, M_AXI_wlast, M_AXI_wvalid,
    output M_AXI_bready,
    input  M_AXI_awready, M_AXI_wready, M_AXI_bresp, M_AXI_bvalid
  );

  modport slave (
    input  M_AXI_awaddr, M_AXI_awlen, M_AXI_awsize, M_AXI_awburst, M_AXI_awvalid,
    input  M_AXI_wdata, M_AXI_wstrb, M_AXI_wlast, M_AXI_wvalid,
    input  M_AXI_bready,
    output M_AXI_awready, M_AXI_wready, M_AXI_bresp, M_AXI_bvalid
  );
endinterface

// File: rtl/s2mm_burst_scheduler.sv
// S2MM burst scheduler: buffers an AXI-Stream sample flow in a FIFO and
// writes it to DDR as fixed-length INCR bursts at the sync manager's current
// write address. One burst in flight at a time.
// Ports:
//   aclk, aresetn       clock, async active-low reset
//   enable              run control; low drains the current burst, then flushes
//   S_AXIS_*            sample stream in (never stalled; tready == enable)
//   SM_write_buffer     next write byte address from the sync manager
//   SM_writing          one-cycle pulse per accepted W beat (registered)
//   m_axi               AXI4 write channels (master modport)
//   overflow_count      saturating count of samples dropped on a full FIFO
//   error               sticky non-OKAY write response flag
module s2mm_burst_scheduler #(
  parameter int MM_ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BURST_LEN      = 16,
  parameter int FIFO_LOG_DEPTH = 5
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     enable,
  input  logic [DATA_WIDTH-1:0]    S_AXIS_tdata,
  input  logic                     S_AXIS_tvalid,
  output logic                     S_AXIS_tready,
  input  logic [MM_ADDR_WIDTH-1:0] SM_write_buffer,
  output logic                     SM_writing,
  s2mm_burst_scheduler_if.master   m_axi,
  output logic [31:0]              overflow_count,
  output logic                     error
);

  localparam int DEPTH  = 1 << FIFO_LOG_DEPTH;
  localparam int BEAT_W = $clog2(BURST_LEN);
  localparam logic [FIFO_LOG_DEPTH:0] BL_C      = (FIFO_LOG_DEPTH+1)'(BURST_LEN);
  localparam logic [BEAT_W-1:0]       LAST_BEAT = BEAT_W'(BURST_LEN-1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]                r_state;
  logic [DATA_WIDTH-1:0]     r_mem [DEPTH];
  logic [FIFO_LOG_DEPTH-1:0] r_wr_ptr, r_rd_ptr;
  logic [FIFO_LOG_DEPTH:0]   r_count;
  logic [MM_ADDR_WIDTH-1:0]  r_awaddr;
  logic                      r_awvalid, r_wvalid, r_bready, r_sm_writing, r_error;
  logic [BEAT_W-1:0]         r_beat;
  logic [31:0]               r_ovf;

  logic w_push_req, w_pop, w_full, w_push, w_drop, w_flush;

  assign w_push_req = S_AXIS_tvalid & enable;
  assign w_pop      = r_wvalid & m_axi.M_AXI_wready;
  // count can never exceed DEPTH, so its MSB alone flags full
  assign w_full     = r_count[FIFO_LOG_DEPTH];
  // a pop in the same cycle frees the slot the push needs
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & w_full & ~w_pop;
  assign w_flush    = (r_state == S_IDLE) & ~enable;

  // Sample storage carries no reset; validity is tracked by count/pointers.
  always_ff @(posedge aclk) begin
    if (w_push) r_mem[r_wr_ptr] <= S_AXIS_tdata;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_ovf <= '0;
    end else if (w_drop && (r_ovf != 32'hFFFF_FFFF)) begin
      r_ovf <= r_ovf + 32'd1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state   <= S_IDLE;
      r_awaddr  <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_beat    <= '0;
      r_error   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (enable && (r_count >= BL_C)) begin
            // address sampled once; the manager only moves it on SM_writing
            r_awaddr  <= SM_write_buffer;
            r_awvalid <= 1'b1;
            r_state   <= S_ADDR;
          end else if (!enable) begin
            r_error <= 1'b0;
          end
        end
        S_ADDR: begin
          if (m_axi.M_AXI_awready) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b1;
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_pop) begin
            if (r_beat == LAST_BEAT) begin
              r_beat   <= '0;
              r_wvalid <= 1'b0;
              r_bready <= 1'b1;
              r_state  <= S_RESP;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        S_RESP: begin
          if (m_axi.M_AXI_bvalid) begin
            if (m_axi.M_AXI_bresp != 2'b00) r_error <= 1'b1;
            r_bready <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_sm_writing <= 1'b0;
    else          r_sm_writing <= w_pop;
  end

  assign S_AXIS_tready         = enable;
  assign SM_writing            = r_sm_writing;
  assign overflow_count        = r_ovf;
  assign error                 = r_error;

  assign m_axi.M_AXI_awaddr    = r_awaddr;
  assign m_axi.M_AXI_awlen     = 8'(BURST_LEN-1);
  assign m_axi.M_AXI_awsize    = 3'($clog2(DATA_WIDTH/8));
  assign m_axi.M_AXI_awburst   = 2'b01;
  assign m_axi.M_AXI_awvalid   = r_awvalid;
  assign m_axi.M_AXI_wdata     = r_mem[r_rd_ptr];
  assign m_axi.M_AXI_wstrb     = '1;
  assign m_axi.M_AXI_wlast     = r_wvalid & (r_beat == LAST_BEAT);
  assign m_axi.M_AXI_wvalid    = r_wvalid;
  assign m_axi.M_AXI_bready    = r_bready;

endmodule

// File: tb/tb_s2mm_burst_scheduler.sv
module tb_s2mm_burst_scheduler;
  logic        aclk = 1'b0;
  logic        aresetn;
  logic        enable;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic [31:0] wbuf;
  logic        sm_writing;
  logic [31:0] ovf;
  logic        err;

  logic wr_toggle_en = 1'b0;
  logic wr_tgl = 1'b0;
  logic wr_base = 1'b1;

  s2mm_burst_scheduler_if #(.MM_ADDR_WIDTH(32), .DATA_WIDTH(32)) m ();

  s2mm_burst_scheduler #(
    .MM_ADDR_WIDTH(32), .DATA_WIDTH(32), .BURST_LEN(16), .FIFO_LOG_DEPTH(5)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable),
    .S_AXIS_tdata(tdata), .S_AXIS_tvalid(tvalid), .S_AXIS_tready(tready),
    .SM_write_buffer(wbuf), .SM_writing(sm_writing),
    .m_axi(m),
    .overflow_count(ovf), .error(err)
  );

  always #5 aclk = ~aclk;

  // wready toggles just after each edge when backpressure is on
  always @(posedge aclk) begin
    #1;
    wr_tgl = ~wr_tgl;
  end
  assign m.M_AXI_wready = wr_toggle_en ? wr_tgl : wr_base;

  int n_chk = 0, n_err = 0;
  int aw_cnt = 0, b_cnt = 0, sm_cnt = 0, nbeats = 0, bt = 0;
  int wlast_err = 0, wv_early = 0, wi = 0;
  logic [31:0] aw_q[$];
  logic [31:0] wq[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Bus observer plus a sync-manager model advancing 4 bytes per beat pulse.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (m.M_AXI_awvalid && m.M_AXI_awready) begin
        aw_cnt++;
        aw_q.push_back(m.M_AXI_awaddr);
      end
      if (m.M_AXI_wvalid && !(nbeats < aw_cnt*16)) wv_early++;
      if (m.M_AXI_wvalid && m.M_AXI_wready) begin
        wq.push_back(m.M_AXI_wdata);
        if (m.M_AXI_wlast !== (bt == 15)) wlast_err++;
        bt = (bt + 1) % 16;
        nbeats++;
      end
      if (sm_writing) begin
        sm_cnt++;
        wbuf = wbuf + 32'd4;
      end
      if (m.M_AXI_bvalid && m.M_AXI_bready) b_cnt++;
    end
  end

  task automatic send(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge aclk); #1;
      tdata  = 32'(first + i);
      tvalid = 1'b1;
    end
    @(posedge aclk); #1;
    tvalid = 1'b0;
  endtask

  task automatic wait_b(input int target);
    int n = 0;
    while (b_cnt < target && n < 2000) begin
      @(posedge aclk);
      n++;
    end
    chk("bresp_count", 64'(b_cnt), 64'(target));
    repeat (2) @(posedge aclk);
    #1;
  endtask

  task automatic wait_beats(input int target);
    int n = 0;
    while (nbeats < target && n < 2000) begin
      @(posedge aclk);
      n++;
    end
    chk("beat_wait", 64'(nbeats >= target), 64'(1));
  endtask

  task automatic check_seq(input string tag, input int first, input int n);
    int bad = 0;
    if (wq.size() < wi + n) bad = n;
    else for (int k = 0; k < n; k++) if (wq[wi+k] !== 32'(first + k)) bad++;
    wi += n;
    chk(tag, 64'(bad), 64'(0));
  endtask

  initial begin
    int aw0;
    aresetn = 1'b0; enable = 1'b0; tdata = '0; tvalid = 1'b0;
    wbuf = 32'h1000_0000;
    m.M_AXI_awready = 1'b1; m.M_AXI_bvalid = 1'b1; m.M_AXI_bresp = 2'b00;
    #3;
    chk("rst_awvalid", 64'(m.M_AXI_awvalid), 64'(0));
    chk("rst_wvalid",  64'(m.M_AXI_wvalid),  64'(0));
    chk("rst_wlast",   64'(m.M_AXI_wlast),   64'(0));
    chk("rst_bready",  64'(m.M_AXI_bready),  64'(0));
    chk("rst_smw",     64'(sm_writing),      64'(0));
    chk("rst_awaddr",  64'(m.M_AXI_awaddr),  64'(0));
    chk("rst_ovf",     64'(ovf),             64'(0));
    chk("rst_error",   64'(err),             64'(0));
    chk("awlen",       64'(m.M_AXI_awlen),   64'(15));
    chk("awsize",      64'(m.M_AXI_awsize),  64'(2));
    chk("awburst",     64'(m.M_AXI_awburst), 64'(1));
    chk("wstrb",       64'(m.M_AXI_wstrb),   64'(4'hF));
    #9 aresetn = 1'b1;
    @(posedge aclk); #1;
    chk("tready_off", 64'(tready), 64'(0));
    enable = 1'b1;
    #1 chk("tready_on", 64'(tready), 64'(1));

    // single burst, no backpressure
    send(0, 16);
    wait_b(1);
    chk("b1_aw_cnt", 64'(aw_cnt), 64'(1));
    check_seq("b1_data", 0, 16);
    chk("b1_sm_cnt", 64'(sm_cnt), 64'(16));

    // wready toggling
    wr_toggle_en = 1'b1;
    send(16, 16);
    wait_b(2);
    wr_toggle_en = 1'b0;
    check_seq("bp_data", 16, 16);
    chk("bp_sm_cnt", 64'(sm_cnt), 64'(32));

    // overflow while AW is stalled
    m.M_AXI_awready = 1'b0;
    send(100, 40);
    chk("ovf_count", 64'(ovf), 64'(8));
    m.M_AXI_awready = 1'b1;
    wait_b(4);
    check_seq("ovf_data", 100, 32);
    chk("ovf_sm_cnt", 64'(sm_cnt), 64'(64));

    // sticky error
    m.M_AXI_bresp = 2'b10;
    send(200, 16);
    wait_b(5);
    m.M_AXI_bresp = 2'b00;
    chk("err_set", 64'(err), 64'(1));
    send(216, 16);
    wait_b(6);
    chk("err_sticky", 64'(err), 64'(1));
    check_seq("err_data", 200, 32);
    enable = 1'b0;
    repeat (2) @(posedge aclk); #1;
    chk("err_clear", 64'(err), 64'(0));
    chk("ovf_retained", 64'(ovf), 64'(8));

    // disable mid-burst; 5 surplus samples must be flushed afterwards
    enable = 1'b1;
    send(300, 21);
    wait_beats(96 + 5);
    @(posedge aclk); #1;
    enable = 1'b0;
    #1 chk("tready_dis", 64'(tready), 64'(0));
    wait_b(7);
    check_seq("dis_data", 300, 16);
    aw0 = aw_cnt;
    repeat (30) @(posedge aclk);
    chk("dis_no_aw", 64'(aw_cnt), 64'(aw0));
    #1 enable = 1'b1;
    send(400, 11);
    repeat (30) @(posedge aclk);
    chk("flush_no_aw", 64'(aw_cnt), 64'(aw0));
    send(411, 5);
    wait_b(8);
    check_seq("flush_data", 400, 16);
    chk("sm_cnt_all", 64'(sm_cnt), 64'(128));
    chk("aw_total", 64'(aw_q.size()), 64'(8));
    for (int i = 0; i < 8 && i < aw_q.size(); i++)
      chk($sformatf("awaddr_%0d", i), 64'(aw_q[i]), 64'(32'h1000_0000 + 32'(i * 64)));
    chk("wlast_errs", 64'(wlast_err), 64'(0));
    chk("wvalid_early", 64'(wv_early), 64'(0));
    chk("no_stray_beats", 64'(wq.size()), 64'(wi));

    // async reset pulse inside DATA
    send(500, 16);
    wait_beats(128 + 3);
    #2 aresetn = 1'b0;
    #1;
    chk("ar_wvalid",  64'(m.M_AXI_wvalid),  64'(0));
    chk("ar_awvalid", 64'(m.M_AXI_awvalid), 64'(0));
    chk("ar_wlast",   64'(m.M_AXI_wlast),   64'(0));
    chk("ar_bready",  64'(m.M_AXI_bready),  64'(0));
    chk("ar_smw",     64'(sm_writing),      64'(0));
    chk("ar_awaddr",  64'(m.M_AXI_awaddr),  64'(0));
    chk("ar_ovf",     64'(ovf),             64'(0));
    chk("ar_error",   64'(err),             64'(0));
    #1 aresetn = 1'b1;
    repeat (3) @(posedge aclk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
